// File: rtl/axis_vector_checker.sv
// AXI4-Stream index/value pair checker that forwards value beats, tagged with their index, through a FIFO.
// Define AXIS_VECTOR_CHECKER_STATS_EN to add the err_idx_cnt, err_last_cnt and stall_cnt counters.
module axis_vector_checker #(
  parameter int DATA_W     = 512,
  parameter int VEC_LEN    = 12,
  parameter int IDX_W      = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  output logic [DATA_W-1:0] m_tdata,
  output logic [IDX_W-1:0]  m_tuser,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              vec_done,
  output logic              err_idx,
  output logic              err_last,
  output logic [1:0]        err_sticky,
  output logic [31:0]       vec_cnt
`ifdef AXIS_VECTOR_CHECKER_STATS_EN
  ,
  output logic [15:0]       err_idx_cnt,
  output logic [15:0]       err_last_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  typedef enum logic {EXP_IDX, EXP_VAL} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              last;
  } entry_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] exp_idx_q, exp_idx_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             bad_q, bad_d;
  logic             vec_done_q, vec_done_d;
  logic             err_idx_q, err_idx_d;
  logic             err_last_q, err_last_d;
  logic [1:0]       sticky_q, sticky_d;
  logic [31:0]      vec_cnt_q, vec_cnt_d;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             valid_q, valid_d;
  entry_t           mem_q [FIFO_DEPTH];

  logic             s_acc, push, pop;
  logic             idx_oor, end_vec, bad_now;
  logic [IDX_W-1:0] idx_in;
  entry_t           push_entry;

  assign s_tready   = !full_q && !areset;
  assign s_acc      = s_tvalid && s_tready;
  assign pop        = valid_q && m_tready;
  assign idx_in     = s_tdata[IDX_W-1:0];
  assign idx_oor    = idx_in > LAST_IDX;
  assign push_entry = '{data: s_tdata, idx: idx_q, last: s_tlast};

  assign m_tvalid   = valid_q;
  assign m_tdata    = mem_q[rd_ptr_q].data;
  assign m_tuser    = mem_q[rd_ptr_q].idx;
  assign m_tlast    = mem_q[rd_ptr_q].last;
  assign vec_done   = vec_done_q;
  assign err_idx    = err_idx_q;
  assign err_last   = err_last_q;
  assign err_sticky = sticky_q;
  assign vec_cnt    = vec_cnt_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    exp_idx_d  = exp_idx_q;
    idx_d      = idx_q;
    bad_d      = bad_q;
    sticky_d   = sticky_q;
    vec_cnt_d  = vec_cnt_q;
    vec_done_d = 1'b0;
    err_idx_d  = 1'b0;
    err_last_d = 1'b0;
    push       = 1'b0;
    end_vec    = 1'b0;
    bad_now    = bad_q;

    if (s_acc) begin
      unique case (state_q)
        EXP_IDX: begin
          idx_d = idx_in;
          if (idx_in != exp_idx_q || idx_oor) begin
            err_idx_d   = 1'b1;
            sticky_d[0] = 1'b1;
            bad_d       = 1'b1;
            // Out-of-range indices cannot be resynced to, so restart from element 0.
            exp_idx_d   = idx_oor ? '0 : idx_in;
          end
          if (s_tlast) begin
            err_last_d  = 1'b1;
            sticky_d[1] = 1'b1;
            exp_idx_d   = '0;
          end else begin
            state_d = EXP_VAL;
          end
        end
        EXP_VAL: begin
          push    = 1'b1;
          end_vec = s_tlast || (idx_q == LAST_IDX);
          if (s_tlast != (idx_q == LAST_IDX)) begin
            err_last_d  = 1'b1;
            sticky_d[1] = 1'b1;
            bad_now     = 1'b1;
          end
          if (end_vec) begin
            exp_idx_d = '0;
            bad_d     = 1'b0;
            if (!bad_now) begin
              vec_done_d = 1'b1;
              vec_cnt_d  = vec_cnt_q + 32'd1;
            end
          end else begin
            bad_d     = bad_now;
            exp_idx_d = (idx_q > LAST_IDX) ? '0 : idx_q + IDX_W'(1);
          end
          state_d = EXP_IDX;
        end
        default: state_d = EXP_IDX;
      endcase
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    full_d   = count_d == CNT_W'(FIFO_DEPTH);
    valid_d  = count_d != '0;
  end

  always_ff @(posedge aclk) begin
    // NOTE: non-blocking assignments, so every flop updates from the same pre-edge values regardless of statement order.
    if (areset) begin
      state_q    <= EXP_IDX;
      exp_idx_q  <= '0;
      idx_q      <= '0;
      bad_q      <= 1'b0;
      vec_done_q <= 1'b0;
      err_idx_q  <= 1'b0;
      err_last_q <= 1'b0;
      sticky_q   <= '0;
      vec_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_idx_q  <= exp_idx_d;
      idx_q      <= idx_d;
      bad_q      <= bad_d;
      vec_done_q <= vec_done_d;
      err_idx_q  <= err_idx_d;
      err_last_q <= err_last_d;
      sticky_q   <= sticky_d;
      vec_cnt_q  <= vec_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      valid_q    <= valid_d;
    end
  end

  // NOTE: storage is deliberately not reset; valid_q and the pointers gate every read, so stale entries are never seen.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

`ifdef AXIS_VECTOR_CHECKER_STATS_EN
  logic [15:0] err_idx_cnt_q, err_idx_cnt_d;
  logic [15:0] err_last_cnt_q, err_last_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    err_idx_cnt_d  = err_idx_cnt_q + 16'(err_idx_d);
    err_last_cnt_d = err_last_cnt_q + 16'(err_last_d);
    stall_cnt_d    = stall_cnt_q + 32'(s_tvalid && !s_tready);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      err_idx_cnt_q  <= '0;
      err_last_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      err_idx_cnt_q  <= err_idx_cnt_d;
      err_last_cnt_q <= err_last_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign err_idx_cnt  = err_idx_cnt_q;
  assign err_last_cnt = err_last_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
